// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous FIFO with show-ahead read.
// Reused for UART byte buffering and for wider command/response words.
//
// Parameters:
//   DATA_WIDTH    bits per entry
//   DEPTH         number of entries (>= 2, any integer, not only powers of two)
//   AFULL_THRESH  almost_full when count >= AFULL_THRESH
//   AEMPTY_THRESH almost_empty when count <= AEMPTY_THRESH
//   ADDR_WIDTH    pointer width
//   CNT_WIDTH     occupancy width (holds the value DEPTH)
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   flush         synchronous clear of contents (error flags are kept)
//   wr_en/wr_data write request and word
//   rd_en         pop request
//   rd_data       head-of-queue word, valid when valid=1
//   valid         rd_data holds a real entry (!empty)
//   full/empty    occupancy == DEPTH / == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         current occupancy
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
//   clr_err       clears overflow/underflow on the next edge

module param_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] rd_ptr_inc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [31:0]           cnt_ext;

    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic udf_set;
    logic ovf_q;
    logic udf_q;

    // Explicit wrap compare so a non-power-of-two DEPTH never
    // lets a pointer run past the last entry.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        if (p == LAST_PTR) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + ADDR_WIDTH'(1);
        end
    endfunction

    // ------------------------------------------------------------
    // Status, all combinational from the registered count
    // ------------------------------------------------------------
    assign cnt_ext      = 32'(cnt);
    assign full         = (cnt == FULL_CNT);
    assign empty        = (cnt == '0);
    assign valid        = ~empty;
    assign almost_full  = (cnt_ext >= 32'(AFULL_THRESH));
    assign almost_empty = (cnt_ext <= 32'(AEMPTY_THRESH));
    assign count        = cnt;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Show-ahead: head word is visible with no read latency.
    assign rd_data = mem[rd_ptr];

    // ------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------
    // A pop in the same cycle frees a slot, so a full FIFO can
    // still take a write when it is also being read.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Flush swallows the cycle's requests, so nothing is flagged.
    assign ovf_set = ~flush & wr_en & ~wr_acc;
    assign udf_set = ~flush & rd_en & empty;

    assign wr_ptr_inc = ptr_inc(wr_ptr);
    assign rd_ptr_inc = ptr_inc(rd_ptr);

    always_comb begin
        cnt_nxt = cnt;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_nxt = cnt + CNT_WIDTH'(1);
            2'b01:   cnt_nxt = cnt - CNT_WIDTH'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // ------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_inc;
            end
            cnt <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------
    // Storage (not reset; contents are meaningless while empty)
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------
    // Sticky error flags; a new error outranks clr_err
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO for generic-width words; next generation of the UART byte buffer.
- Sits between the UART RX/TX byte path and the register-access command parser, and is reusable for wider response words.
- Adds configurable width and depth (including non-power-of-two), show-ahead read, occupancy count, programmable almost-full/almost-empty flags, flush, and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- DEPTH, 16, number of entries; any integer >= 2, not restricted to powers of two.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH.
- ADDR_WIDTH, $clog2(DEPTH), pointer width.
- CNT_WIDTH, $clog2(DEPTH+1), count width; must hold the value DEPTH.

Ports:
- clk  in  1  rising-edge clock; only clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; does not clear error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_WIDTH  head-of-queue word (show-ahead).
- valid  out  1  rd_data holds a real entry (= !empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  CNT_WIDTH  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow/underflow next edge.

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Outputs then read empty=1, valid=0, full=0, almost_empty=1, almost_full=0 (almost_full=1 only if AFULL_THRESH==0).
- rst has priority over flush, clr_err, wr_en and rd_en. Reset mid-stream discards all contents. Memory array is not reset; rd_data is don't-care while valid=0.
- All flags and count are derived combinationally from the registered count; no extra latency.
- Write accepted (wr_acc) = wr_en & (!full | rd_acc). Store wr_data at mem[wr_ptr] and advance wr_ptr.
- The data value never gates acceptance; 0x00 is a legal word.
- Read accepted (rd_acc) = rd_en & !empty. Advance rd_ptr.
- rd_data = mem[rd_ptr] combinationally, so the head word is visible with no read latency (show-ahead).
- Write-to-read latency: a word written at edge N is on rd_data, with valid=1, after edge N when the FIFO was empty.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0 (explicit compare, not natural overflow), so non-power-of-two DEPTH works.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Full with wr_en=1 and rd_en=1: both accepted; count stays DEPTH; no overflow.
- Full with wr_en=1 and rd_en=0: write dropped; memory and pointers untouched; overflow<=1.
- Empty with rd_en=1: read rejected; underflow<=1. A simultaneous write is still accepted, giving count=1.
- flush=1 (rst=0): pointers and count go to 0; any same-cycle wr_en/rd_en is ignored and sets no error flags.
- Error flags: set has priority over clear when clr_err coincides with a new error. Otherwise clr_err=1 clears both flags.

Test Plan:
- Reset, then write 0x00,0x11,0x22 on three consecutive cycles -> count=3, rd_data=0x00 with valid=1 after the first edge. Pop three -> rd_data 0x11, then 0x22, then empty=1, almost_empty=1.
- DEPTH=5 (non-power-of-two): write 5 words -> full=1, almost_full=1 from count=3. Write 0xAA -> overflow=1, count=5. Pop one and write one, repeated 12 times -> data order preserved across pointer wrap.
- Full FIFO with wr_en=1 and rd_en=1 on the same cycle -> count stays DEPTH, overflow=0, head advances, new word lands at the tail.
- Empty FIFO with rd_en=1 and wr_en=1 (0x5C) -> underflow=1, count=1, rd_data=0x5C. Next cycle clr_err=1 -> underflow=0.
- count=4, assert flush with wr_en=1 -> count=0, empty=1, no error flags. Assert rst mid-stream with count=7 -> all reset values next cycle.
- DATA_WIDTH=32, DEPTH=16: random wr_en/rd_en traffic for 2000 cycles, compared against a queue model -> rd_data, count and all flags match every cycle.
